// File: rtl/spe_omem_arbiter.sv
// Round-robin arbiter sharing the single OMEM port among N_SPE sum PEs.
// One transaction in flight; reads hold the port until the response is delivered.
module spe_omem_arbiter #(
  parameter int N_SPE      = 4,
  parameter int PKT_W      = 33,
  parameter int OMEM_ID    = 12,
  parameter int PE_ID_BASE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SPE-1:0]       req_valid,
  output logic [N_SPE-1:0]       req_ready,
  input  logic [N_SPE*PKT_W-1:0] req_packet,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [PKT_W-1:0]       mem_packet,
  input  logic                   mem_rsp_valid,
  output logic                   mem_rsp_ready,
  input  logic [24:0]            mem_rsp_data,
  output logic [N_SPE-1:0]       rsp_valid,
  input  logic [N_SPE-1:0]       rsp_ready,
  output logic [24:0]            rsp_data,
  output logic                   err,
  output logic [15:0]            txn_count
);
  localparam int PW = $clog2(N_SPE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    rr_ptr, g, win;
  logic             found, accept, bad, done;
  logic [PKT_W-1:0] pkt, sel_pkt;
  int               idx;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_SPE; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_SPE) idx = idx - N_SPE;
      if (!found && req_valid[idx]) begin
        win   = PW'(idx);
        found = 1'b1;
      end
    end
  end

  assign sel_pkt = req_packet[int'(win)*PKT_W +: PKT_W];
  assign accept  = (state == IDLE) && found;
  // Packet is forwarded regardless; a mismatch only raises the sticky flag.
  assign bad     = (sel_pkt[32:29] != 4'(OMEM_ID)) ||
                   (sel_pkt[28:26] != 3'(PE_ID_BASE + int'(win)));

  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    mem_rsp_ready = 1'b0;
    rsp_valid     = '0;
    done          = 1'b0;
    case (state)
      IDLE: if (found) begin
        req_ready[win] = 1'b1;
        state_nxt      = ISSUE;
      end
      ISSUE: if (mem_ready) begin
        if (pkt[25]) state_nxt = WAIT_RSP;
        else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_RSP: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) state_nxt = DELIVER;
      end
      DELIVER: begin
        rsp_valid[g] = 1'b1;
        if (rsp_ready[g]) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_valid  = (state == ISSUE);
  assign mem_packet = pkt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      g         <= '0;
      pkt       <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
      txn_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pkt <= sel_pkt;
        g   <= win;
      end
      if (state == WAIT_RSP && mem_rsp_valid) rsp_data <= mem_rsp_data;
      if ((accept && bad) || (mem_rsp_valid && state != WAIT_RSP)) err <= 1'b1;
      if (done) begin
        rr_ptr    <= (g == PW'(N_SPE-1)) ? '0 : g + 1'b1;
        txn_count <= txn_count + 16'd1;
      end
    end
  end
endmodule
